mem_arbiter: RTL and testbench

Sequences and shares the single main-memory port between the iCache fill path and the dCache fill/write-back path. Each cache raises a line request; the arbiter grants one at a time, drives the memory request, returns the 128-bit line with a one-cycle ready pulse, and performs a dirty-line write-back before the dCache fill. It sits between both caches and the memory model, and is the only block that drives memory request signals.

---
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the iCache, dCache and main-memory signals that
//                meet at the memory arbiter.
//                  iCache : ic_req, ic_addr -> ic_rdy, ic_data
//                  dCache : dc_req, dc_addr, dc_wb, dc_wb_addr, dc_wb_data
//                           -> dc_rdy, dc_data
//                  Memory : mem_req, mem_we, mem_addr, mem_wdata
//                           <- mem_rdata, mem_rdy
//                The slave modport is the arbiter's view. The master modport
//                is the view of the environment, which holds both caches and
//                the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    // iCache fill path
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_rdy;
    logic [LINE_W-1:0] ic_data;
    // dCache fill / write-back path
    logic              dc_req;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_wb;
    logic [ADDR_W-1:0] dc_wb_addr;
    logic [LINE_W-1:0] dc_wb_data;
    logic              dc_rdy;
    logic [LINE_W-1:0] dc_data;
    // main-memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_rdy;

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_addr, dc_wb, dc_wb_addr, dc_wb_data,
        input  mem_rdata, mem_rdy,
        output ic_rdy, ic_data, dc_rdy, dc_data,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_addr, dc_wb, dc_wb_addr, dc_wb_data,
        output mem_rdata, mem_rdy,
        input  ic_rdy, ic_data, dc_rdy, dc_data,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares the single main-memory port between the iCache fill
//                path and the dCache fill/write-back path. One request is
//                granted at a time. A dirty dCache line is written back
//                before the fill read. The line is returned with a
//                one-cycle rdy pulse.
//  Ports       : clk     - clock, all logic on posedge
//                reset   - synchronous, active-high
//                bus     - mem_arbiter_if.slave (cache and memory signals)
//                busy    - arbiter not idle
//                mem_err - sticky watchdog error
//  Options     : MEM_ARB_TIMEOUT_EN - when defined, a watchdog of TIMEOUT
//                cycles is built. The watchdog aborts a memory access that
//                never completes. When not defined, mem_err is constant 0 and
//                the arbiter waits for mem_rdy indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mem_arbiter_if.slave     bus,
    output logic             busy,
    output logic             mem_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_I_RD = 3'd1;
    localparam logic [2:0] S_D_WB = 3'd2;
    localparam logic [2:0] S_D_RD = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]        r_state,     w_state_nxt;
    logic              r_last_d,    w_last_d_nxt;   // 1 = last grant went to dCache
    logic              r_mem_req,   w_mem_req_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [LINE_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_ic_rdy,    w_ic_rdy_nxt;
    logic              r_dc_rdy,    w_dc_rdy_nxt;
    logic [LINE_W-1:0] r_ic_data,   w_ic_data_nxt;
    logic [LINE_W-1:0] r_dc_data,   w_dc_data_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_mem_err,   w_mem_err_nxt;
    logic              w_timeout;

    // State and all outputs are registered together. Each output is computed
    // from the next state, so it changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last_d    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ic_rdy    <= 1'b0;
            r_dc_rdy    <= 1'b0;
            r_ic_data   <= '0;
            r_dc_data   <= '0;
            r_busy      <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_d    <= w_last_d_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_ic_rdy    <= w_ic_rdy_nxt;
            r_dc_rdy    <= w_dc_rdy_nxt;
            r_ic_data   <= w_ic_data_nxt;
            r_dc_data   <= w_dc_data_nxt;
            r_busy      <= w_busy_nxt;
            r_mem_err   <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_last_d_nxt  = r_last_d;
        w_ic_rdy_nxt  = 1'b0;
        w_dc_rdy_nxt  = 1'b0;
        w_ic_data_nxt = r_ic_data;
        w_dc_data_nxt = r_dc_data;
        w_mem_err_nxt = r_mem_err;

        case (r_state)
            S_IDLE: begin
                // On a conflict, grant the side that was not granted last.
                if (bus.dc_req && (!bus.ic_req || !r_last_d)) begin
                    w_last_d_nxt = 1'b1;
                    w_state_nxt  = bus.dc_wb ? S_D_WB : S_D_RD;
                end else if (bus.ic_req) begin
                    w_last_d_nxt = 1'b0;
                    w_state_nxt  = S_I_RD;
                end
            end
            S_I_RD: begin
                if (bus.mem_rdy) begin
                    w_ic_data_nxt = bus.mem_rdata;
                    w_ic_rdy_nxt  = 1'b1;
                    w_state_nxt   = S_RESP;
                end else if (w_timeout) begin
                    w_ic_data_nxt = '0;
                    w_ic_rdy_nxt  = 1'b1;
                    w_mem_err_nxt = 1'b1;
                    w_state_nxt   = S_RESP;
                end
            end
            S_D_WB: begin
                if (bus.mem_rdy) begin
                    w_state_nxt = S_D_RD;
                end else if (w_timeout) begin
                    // An aborted write-back also abandons the fill read.
                    w_dc_data_nxt = '0;
                    w_dc_rdy_nxt  = 1'b1;
                    w_mem_err_nxt = 1'b1;
                    w_state_nxt   = S_RESP;
                end
            end
            S_D_RD: begin
                if (bus.mem_rdy) begin
                    w_dc_data_nxt = bus.mem_rdata;
                    w_dc_rdy_nxt  = 1'b1;
                    w_state_nxt   = S_RESP;
                end else if (w_timeout) begin
                    w_dc_data_nxt = '0;
                    w_dc_rdy_nxt  = 1'b1;
                    w_mem_err_nxt = 1'b1;
                    w_state_nxt   = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;   // requests are not looked at here
            default: w_state_nxt = S_IDLE;
        endcase

        // Memory-side outputs follow the state being entered.
        w_mem_req_nxt   = (w_state_nxt == S_I_RD) || (w_state_nxt == S_D_WB) ||
                          (w_state_nxt == S_D_RD);
        w_mem_we_nxt    = (w_state_nxt == S_D_WB);
        w_mem_wdata_nxt = (w_state_nxt == S_D_WB) ? bus.dc_wb_data : '0;
        case (w_state_nxt)
            S_I_RD:  w_mem_addr_nxt = bus.ic_addr;
            S_D_WB:  w_mem_addr_nxt = bus.dc_wb_addr;
            S_D_RD:  w_mem_addr_nxt = bus.dc_addr;
            default: w_mem_addr_nxt = '0;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // The watchdog counts the cycles spent in the current memory state. It
    // restarts on every state change, so D_WB and D_RD each get their own
    // full budget.
    localparam int c_WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [c_WD_W-1:0] r_wd;

    assign w_timeout = (r_wd == c_WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd <= '0;
        end else if (w_state_nxt != r_state) begin
            r_wd <= '0;
        end else if (r_mem_req) begin
            r_wd <= r_wd + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.ic_rdy    = r_ic_rdy;
    assign bus.dc_rdy    = r_dc_rdy;
    assign bus.ic_data   = r_ic_data;
    assign bus.dc_data   = r_dc_data;
    assign busy          = r_busy;
    assign mem_err       = r_mem_err;   // stays 0 when no watchdog is built

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A table of request
//                scenarios is applied to the arbiter, which is connected to
//                a memory model with a programmable number of wait states.
//                Expected returned lines and expected memory operations are
//                queued when a scenario starts. The queues are popped when
//                the arbiter produces a rdy pulse or completes a memory
//                access. Hand-written sequences cover exact cycle timing,
//                reset in the middle of a transaction, and the watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic mem_err;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) arb ();

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (arb.slave),
        .busy    (busy),
        .mem_err (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ic;
        bit          dc;
        bit          wb;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wa;
        logic [127:0] wd;
        int          waits;
        bit          exp_dc_first;
    } vec_t;

    typedef struct {
        bit           is_dc;
        logic [127:0] data;
    } rsp_t;

    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } op_t;

    rsp_t rsp_q[$];
    op_t  op_q[$];
    vec_t vecs[7];

    int checks   = 0;
    int failures = 0;
    bit mem_auto = 1'b0;
    int mem_waits = 0;
    int wcnt = 0;
    bit prev_ic_rdy = 1'b0;
    bit prev_dc_rdy = 1'b0;

    localparam logic [127:0] LINE_A = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;

    function automatic logic [127:0] mem_model(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A5A5A, a + 32'h12345678};
    endfunction

    function automatic vec_t mkv(input bit ic, input bit dc, input bit wb,
                                 input logic [31:0] ia, input logic [31:0] da,
                                 input logic [31:0] wa, input int waits,
                                 input bit exp_dc_first);
        vec_t v;
        v.ic = ic; v.dc = dc; v.wb = wb;
        v.ia = ia; v.da = da; v.wa = wa;
        v.wd = {wa, 32'hDEAD0000, ~wa, 32'h0000BEEF};
        v.waits = waits;
        v.exp_dc_first = exp_dc_first;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Memory model: at each falling edge, decide whether the access
    // currently presented completes at the next rising edge.
    task automatic mem_step();
        if (!mem_auto) return;
        if (arb.mem_req) begin
            if (wcnt >= mem_waits) begin
                arb.mem_rdy   = 1'b1;
                arb.mem_rdata = mem_model(arb.mem_addr);
                if (op_q.size() == 0) begin
                    chk("mem_op_unexpected", {arb.mem_we, arb.mem_addr}, 33'h0);
                    if (!arb.mem_we && arb.mem_addr == 32'h0) begin
                        failures++;
                        $display("FAIL mem_op_unexpected actual=read@0 expected=none");
                    end
                end else begin
                    op_t e;
                    e = op_q.pop_front();
                    chk("mem_op_we_addr", {arb.mem_we, arb.mem_addr}, {e.we, e.addr});
                    if (e.we) chk("mem_op_wdata", arb.mem_wdata, e.wdata);
                end
                wcnt = 0;
            end else begin
                arb.mem_rdy = 1'b0;
                wcnt++;
            end
        end else begin
            arb.mem_rdy = 1'b0;
            wcnt = 0;
        end
    endtask

    task automatic rsp_check(input bit is_dc, input logic [127:0] data, input bit prev);
        chk(is_dc ? "dc_rdy_single_cycle" : "ic_rdy_single_cycle", prev, 1'b0);
        if (rsp_q.size() == 0) begin
            chk(is_dc ? "dc_rdy_unexpected" : "ic_rdy_unexpected", 1'b1, 1'b0);
        end else begin
            rsp_t e;
            e = rsp_q.pop_front();
            chk(is_dc ? "dc_response" : "ic_response", {is_dc, data}, {e.is_dc, e.data});
        end
    endtask

    task automatic mon_step();
        if (arb.ic_rdy) begin
            rsp_check(1'b0, arb.ic_data, prev_ic_rdy);
            arb.ic_req = 1'b0;
        end
        if (arb.dc_rdy) begin
            rsp_check(1'b1, arb.dc_data, prev_dc_rdy);
            arb.dc_req = 1'b0;
        end
        prev_ic_rdy = arb.ic_rdy;
        prev_dc_rdy = arb.dc_rdy;
    endtask

    task automatic tick();
        @(negedge clk);
        mem_step();
        mon_step();
    endtask

    task automatic push_side(input bit is_dc, input vec_t v);
        rsp_t r;
        op_t  o;
        r.is_dc = is_dc;
        if (is_dc) begin
            if (v.wb) begin
                o.we = 1'b1; o.addr = v.wa; o.wdata = v.wd;
                op_q.push_back(o);
            end
            o.we = 1'b0; o.addr = v.da; o.wdata = '0;
            op_q.push_back(o);
            r.data = mem_model(v.da);
        end else begin
            o.we = 1'b0; o.addr = v.ia; o.wdata = '0;
            op_q.push_back(o);
            r.data = mem_model(v.ia);
        end
        rsp_q.push_back(r);
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int c;
        c = 0;
        while (busy && c < 20) begin
            tick();
            c++;
        end
        arb.ic_addr    = v.ia;
        arb.dc_addr    = v.da;
        arb.dc_wb      = v.wb;
        arb.dc_wb_addr = v.wa;
        arb.dc_wb_data = v.wd;
        mem_waits      = v.waits;
        if (v.ic && v.dc) begin
            push_side(v.exp_dc_first, v);
            push_side(!v.exp_dc_first, v);
        end else if (v.dc) begin
            push_side(1'b1, v);
        end else if (v.ic) begin
            push_side(1'b0, v);
        end
        arb.ic_req = v.ic;
        arb.dc_req = v.dc;
        c = 0;
        while (rsp_q.size() != 0 && c < 300) begin
            tick();
            c++;
        end
        if (rsp_q.size() != 0) begin
            failures++;
            $display("FAIL vec%0d_timeout actual=%0d_pending expected=0", idx, rsp_q.size());
            rsp_q.delete();
        end
        chk($sformatf("vec%0d_mem_ops_done", idx), op_q.size(), 0);
        op_q.delete();
        tick();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        arb.ic_req     = 1'b0;
        arb.ic_addr    = '0;
        arb.dc_req     = 1'b0;
        arb.dc_addr    = '0;
        arb.dc_wb      = 1'b0;
        arb.dc_wb_addr = '0;
        arb.dc_wb_data = '0;
        arb.mem_rdy    = 1'b0;
        arb.mem_rdata  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev_ic_rdy = 1'b0;
        prev_dc_rdy = 1'b0;
        wcnt = 0;
    endtask

    initial begin
        int cnt;
        bit got;

        // Columns: ic, dc, wb, ic_addr, dc_addr, wb_addr, wait states,
        // dCache expected first. last_d is 0 when the table starts.
        vecs[0] = mkv(1, 1, 0, 32'h200, 32'h300, 32'h0,   0, 1); // first conflict -> dCache
        vecs[1] = mkv(1, 0, 0, 32'h40,  32'h0,   32'h0,   0, 0);
        vecs[2] = mkv(0, 1, 1, 32'h0,   32'h100, 32'h80,  2, 1); // dirty miss, 2 waits
        vecs[3] = mkv(1, 1, 0, 32'h240, 32'h340, 32'h0,   0, 0); // last was dCache -> iCache
        vecs[4] = mkv(1, 1, 1, 32'h400, 32'h500, 32'h600, 1, 0);
        vecs[5] = mkv(1, 0, 0, 32'h700, 32'h0,   32'h0,   3, 0);
        vecs[6] = mkv(1, 1, 0, 32'h800, 32'h900, 32'h0,   0, 1); // last was iCache -> dCache

        do_reset();
        chk("reset_busy",    busy,         1'b0);
        chk("reset_mem_req", arb.mem_req,  1'b0);
        chk("reset_rdy",     {arb.ic_rdy, arb.dc_rdy}, 2'b00);
        chk("reset_mem_err", mem_err,      1'b0);
        chk("reset_mem_addr", arb.mem_addr, 32'h0);

        // Single iCache read, zero-wait memory, exact cycle timing.
        arb.ic_addr = 32'h40;
        arb.ic_req  = 1'b1;
        @(negedge clk);
        chk("seq1_mem_req", {arb.mem_req, arb.mem_we}, 2'b10);
        chk("seq1_mem_addr", arb.mem_addr, 32'h40);
        chk("seq1_busy_ic_rdy", {busy, arb.ic_rdy}, 2'b10);
        arb.mem_rdata = LINE_A;
        arb.mem_rdy   = 1'b1;
        @(negedge clk);
        chk("seq1_ic_rdy", {arb.ic_rdy, arb.dc_rdy, arb.mem_req}, 3'b100);
        chk("seq1_ic_data", arb.ic_data, LINE_A);
        arb.ic_req    = 1'b0;
        arb.mem_rdy   = 1'b0;
        arb.mem_rdata = '0;
        @(negedge clk);
        chk("seq1_idle", {arb.ic_rdy, busy}, 2'b00);

        // Table-driven scenarios against the memory model.
        do_reset();
        mem_auto = 1'b1;
        for (int i = 0; i < 7; i++) run_vector(i, vecs[i]);
        mem_auto = 1'b0;

        // Reset while a dCache read is outstanding.
        arb.dc_addr = 32'h100;
        arb.dc_wb   = 1'b0;
        arb.dc_req  = 1'b1;
        @(negedge clk);
        chk("rst_seq_d_rd", {arb.mem_req, arb.mem_we, arb.mem_addr}, {2'b10, 32'h100});
        reset = 1'b1;
        @(negedge clk);
        chk("rst_seq_mem_outputs", {arb.mem_req, arb.mem_we, arb.mem_addr}, 34'h0);
        chk("rst_seq_wdata", arb.mem_wdata, 128'h0);
        chk("rst_seq_status", {arb.ic_rdy, arb.dc_rdy, busy, mem_err}, 4'h0);
        chk("rst_seq_ic_data", arb.ic_data, 128'h0);
        chk("rst_seq_dc_data", arb.dc_data, 128'h0);
        reset         = 1'b0;
        arb.dc_req    = 1'b0;
        arb.mem_rdata = LINE_A;
        arb.mem_rdy   = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (arb.ic_rdy || arb.dc_rdy || busy) cnt++;
        end
        chk("stray_mem_rdy_ignored", cnt, 0);
        arb.mem_rdy   = 1'b0;
        arb.mem_rdata = '0;

        // The dCache was granted last before reset; last_d must be back to
        // 0, so a new conflict goes to the dCache again.
        mem_auto = 1'b1;
        run_vector(7, mkv(1, 1, 0, 32'hA00, 32'hB00, 32'h0, 0, 1));
        mem_auto = 1'b0;

        // Memory that never answers.
        arb.ic_addr = 32'hC40;
        arb.ic_req  = 1'b1;
        cnt = 0;
        got = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (arb.ic_rdy) begin
                got = 1'b1;
                break;
            end
            if (arb.mem_req) cnt++;
        end
        chk("wd_rdy_seen", got, 1'b1);
        chk("wd_cycles_in_i_rd", cnt, 8);
        chk("wd_data_zero", arb.ic_data, 128'h0);
        chk("wd_mem_err_set", mem_err, 1'b1);
        arb.ic_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("wd_mem_err_sticky", {mem_err, busy}, 2'b10);
        do_reset();
        chk("wd_mem_err_cleared", mem_err, 1'b0);
`else
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (arb.ic_rdy) got = 1'b1;
            if (arb.mem_req) cnt++;
        end
        chk("nowd_still_waiting", {got, arb.mem_req, mem_err}, 3'b010);
        chk("nowd_mem_req_cycles", cnt, 30);
        arb.mem_rdata = LINE_A;
        arb.mem_rdy   = 1'b1;
        @(negedge clk);
        chk("nowd_late_completion", {arb.ic_rdy, arb.ic_data}, {1'b1, LINE_A});
        arb.ic_req    = 1'b0;
        arb.mem_rdy   = 1'b0;
        @(negedge clk);
        chk("nowd_idle", {busy, mem_err}, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
